// File: rtl/if_id_unpack_if.sv
// IF/ID bundle interface: fetch-side bundle and controls in, unpacked ID fields out.
interface if_id_unpack_if #(
   parameter int WIDTH = 83
);
   logic [0:WIDTH-1] if_bundle;
   logic             if_valid;
   logic             stall_in;
   logic             flush_in;
   logic             id_valid;
   logic [0:31]      id_nextPC;
   logic [0:31]      id_instr;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic [0:18]      id_ctrl;
   logic             stall_if;
   logic             ex_bubble;

   modport master (
      output if_bundle, if_valid, stall_in, flush_in,
      input  id_valid, id_nextPC, id_instr, id_rs1, id_rs2, id_rd, id_ctrl,
      input  stall_if, ex_bubble
   );

   modport slave (
      input  if_bundle, if_valid, stall_in, flush_in,
      output id_valid, id_nextPC, id_instr, id_rs1, id_rs2, id_rd, id_ctrl,
      output stall_if, ex_bubble
   );
endinterface

// File: rtl/if_id_unpack.sv
// IF/ID register: latches the fetch bundle, unpacks ID fields, tracks the
// instruction issued to EX for load-use detection, and applies stall/flush.
// Bundle bits use ascending numbering: bit 0 is the MSB of nextPC.
module if_id_unpack #(
   parameter int          WIDTH     = 83,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input logic          clk,
   input logic          reset,
   if_id_unpack_if.slave bus
);
   // Control field positions inside id_ctrl (bundle bit minus 64).
   localparam int CT_RTYPE    = 5;
   localparam int CT_REGWRITE = 6;
   localparam int CT_MEMTOREG = 7;
   localparam int CT_MEMWRITE = 8;

   logic        valid_q,   valid_d;
   logic [0:31] nextpc_q,  nextpc_d;
   logic [0:31] instr_q,   instr_d;
   logic [0:18] ctrl_q,    ctrl_d;
   logic        ex_load_q, ex_load_d;
   logic [4:0]  ex_dest_q, ex_dest_d;

   logic [4:0]  rs1, rs2, rd;
   logic        rs2_used;
   logic        hazard;
   logic        id_is_load;

   // Field decode and load-use detection from registered state only.
   always_comb begin
      rs1        = instr_q[6:10];
      rs2        = instr_q[11:15];
      rd         = ctrl_q[CT_RTYPE] ? instr_q[16:20] : instr_q[11:15];
      rs2_used   = ctrl_q[CT_RTYPE] | ctrl_q[CT_MEMWRITE];
      id_is_load = valid_q & ctrl_q[CT_MEMTOREG] & ctrl_q[CT_REGWRITE];
      hazard     = valid_q & ex_load_q & (ex_dest_q != 5'd0) &
                   ((rs1 == ex_dest_q) | (rs2_used & (rs2 == ex_dest_q)));
   end

   // Next-state selection: flush > stall_in > hazard > normal advance.
   always_comb begin
      valid_d   = valid_q;
      nextpc_d  = nextpc_q;
      instr_d   = instr_q;
      ctrl_d    = ctrl_q;
      ex_load_d = ex_load_q;
      ex_dest_d = ex_dest_q;
      if (bus.flush_in) begin
         valid_d  = 1'b0;
         nextpc_d = '0;
         instr_d  = NOP_INSTR;
         ctrl_d   = '0;
         // A concurrent stall_in freezes EX, so its tracking must not move.
         if (!bus.stall_in) begin
            ex_load_d = id_is_load;
            ex_dest_d = rd;
         end
      end else if (bus.stall_in) begin
         // hold everything
      end else if (hazard) begin
         // The bubble enters EX, which releases the hazard next cycle.
         ex_load_d = 1'b0;
         ex_dest_d = 5'd0;
      end else begin
         ex_load_d = id_is_load;
         ex_dest_d = rd;
         valid_d   = bus.if_valid;
         nextpc_d  = bus.if_bundle[0:31];
         instr_d   = bus.if_bundle[32:63];
         ctrl_d    = bus.if_valid ? bus.if_bundle[64:WIDTH-1] : '0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         nextpc_q  <= '0;
         instr_q   <= NOP_INSTR;
         ctrl_q    <= '0;
         ex_load_q <= 1'b0;
         ex_dest_q <= 5'd0;
      end else begin
         valid_q   <= valid_d;
         nextpc_q  <= nextpc_d;
         instr_q   <= instr_d;
         ctrl_q    <= ctrl_d;
         ex_load_q <= ex_load_d;
         ex_dest_q <= ex_dest_d;
      end
   end

   assign bus.id_valid  = valid_q;
   assign bus.id_nextPC = nextpc_q;
   assign bus.id_instr  = instr_q;
   assign bus.id_ctrl   = ctrl_q;
   assign bus.id_rs1    = rs1;
   assign bus.id_rs2    = rs2;
   assign bus.id_rd     = rd;
   assign bus.stall_if  = hazard | bus.stall_in;
   assign bus.ex_bubble = hazard & ~bus.stall_in & ~bus.flush_in;
endmodule

// File: tb/tb_if_id_unpack.sv
// Directed vector bench for if_id_unpack.
module tb_if_id_unpack;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   if_id_unpack_if #(.WIDTH(83)) bus ();

   if_id_unpack #(.WIDTH(83), .NOP_INSTR(32'h00000000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [0:31] pc;
      logic [0:31] ins;
      logic [0:18] ctl;
      logic        v;
      logic        st;
      logic        fl;
      logic        e_v;
      logic [0:31] e_pc;
      logic [0:31] e_ins;
      logic [0:18] e_ctl;
      logic [4:0]  e_rd;
      logic        e_sif;
      logic        e_bub;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [0:31] rtype(int rs1, int rs2, int rd);
      return {6'h00, 5'(rs1), 5'(rs2), 5'(rd), 11'h020};
   endfunction

   function automatic logic [0:31] itype(int op, int rs1, int rt, int imm);
      return {6'(op), 5'(rs1), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [0:18] mkc(bit r, bit rw, bit m2r, bit mw);
      logic [0:18] c;
      c    = '0;
      c[5] = r;
      c[6] = rw;
      c[7] = m2r;
      c[8] = mw;
      return c;
   endfunction

   task automatic add(input logic [0:31] pc, input logic [0:31] ins, input logic [0:18] ctl,
                      input logic v, input logic st, input logic fl,
                      input logic e_v, input logic [0:31] e_pc, input logic [0:31] e_ins,
                      input logic [0:18] e_ctl, input int e_rd, input logic e_sif, input logic e_bub);
      vec_t t;
      t.pc = pc; t.ins = ins; t.ctl = ctl; t.v = v; t.st = st; t.fl = fl;
      t.e_v = e_v; t.e_pc = e_pc; t.e_ins = e_ins; t.e_ctl = e_ctl;
      t.e_rd = 5'(e_rd); t.e_sif = e_sif; t.e_bub = e_bub;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic [0:31] pc, input logic [0:31] ins, input logic [0:18] ctl,
                        input logic v, input logic st, input logic fl);
      bus.if_bundle = {pc, ins, ctl};
      bus.if_valid  = v;
      bus.stall_in  = st;
      bus.flush_in  = fl;
   endtask

   logic [0:31] A, LW5, ADD6, NX, LW0, USE0, LW5B, ADDI, X, LWA, LWB, ADD7, Y;
   logic [0:31] ADDR2, Z, W1, W2, W3, INV, ADD8, Q;
   logic [0:18] CR, CL, CI, C0;
   logic [0:31] Z32;

   initial begin
      errors = 0;
      checks = 0;
      A = rtype(1, 2, 3);      LW5 = itype(8'h23, 1, 5, 0); ADD6 = rtype(5, 1, 6);
      NX = rtype(1, 2, 7);     LW0 = itype(8'h23, 2, 0, 0); USE0 = rtype(0, 0, 9);
      LW5B = itype(8'h23, 3, 5, 0); ADDI = itype(8'h08, 2, 5, 4); X = rtype(1, 2, 10);
      LWA = itype(8'h23, 1, 5, 0);  LWB = itype(8'h23, 5, 6, 0);  ADD7 = rtype(6, 1, 7);
      Y = rtype(1, 2, 11);     ADDR2 = rtype(1, 5, 12); Z = rtype(1, 2, 13);
      W1 = rtype(2, 3, 14);    W2 = rtype(3, 4, 15);    W3 = rtype(4, 5, 16);
      INV = rtype(1, 2, 17);   ADD8 = rtype(5, 1, 8);   Q = rtype(1, 2, 18);
      CR = mkc(1, 1, 0, 0); CL = mkc(0, 1, 1, 0); CI = mkc(0, 1, 0, 0); C0 = '0; Z32 = '0;

      //  inputs: pc, instr, ctrl, valid, stall, flush | expected: valid, pc, instr, ctrl, rd, stall_if, ex_bubble
      add(32'h104, A, CR, 1, 0, 0,      0, Z32, Z32, C0, 0, 0, 0);
      add(32'h108, A, CR, 1, 0, 0,      1, 32'h104, A, CR, 3, 0, 0);
      add(32'h10C, A, CR, 1, 0, 0,      1, 32'h108, A, CR, 3, 0, 0);
      add(32'h110, LW5, CL, 1, 0, 0,    1, 32'h10C, A, CR, 3, 0, 0);
      add(32'h114, ADD6, CR, 1, 0, 0,   1, 32'h110, LW5, CL, 5, 0, 0);
      add(32'h118, NX, CR, 1, 0, 0,     1, 32'h114, ADD6, CR, 6, 1, 1);
      add(32'h118, NX, CR, 1, 0, 0,     1, 32'h114, ADD6, CR, 6, 0, 0);
      add(32'h11C, LW0, CL, 1, 0, 0,    1, 32'h118, NX, CR, 7, 0, 0);
      add(32'h120, USE0, CR, 1, 0, 0,   1, 32'h11C, LW0, CL, 0, 0, 0);
      add(32'h124, LW5B, CL, 1, 0, 0,   1, 32'h120, USE0, CR, 9, 0, 0);
      add(32'h128, ADDI, CI, 1, 0, 0,   1, 32'h124, LW5B, CL, 5, 0, 0);
      add(32'h12C, X, CR, 1, 0, 0,      1, 32'h128, ADDI, CI, 5, 0, 0);
      add(32'h130, LWA, CL, 1, 0, 0,    1, 32'h12C, X, CR, 10, 0, 0);
      add(32'h134, LWB, CL, 1, 0, 0,    1, 32'h130, LWA, CL, 5, 0, 0);
      add(32'h138, ADD7, CR, 1, 0, 0,   1, 32'h134, LWB, CL, 6, 1, 1);
      add(32'h138, ADD7, CR, 1, 0, 0,   1, 32'h134, LWB, CL, 6, 0, 0);
      add(32'h13C, Y, CR, 1, 0, 0,      1, 32'h138, ADD7, CR, 7, 1, 1);
      add(32'h13C, Y, CR, 1, 0, 0,      1, 32'h138, ADD7, CR, 7, 0, 0);
      add(32'h140, LW5, CL, 1, 0, 0,    1, 32'h13C, Y, CR, 11, 0, 0);
      add(32'h144, ADDR2, CR, 1, 0, 0,  1, 32'h140, LW5, CL, 5, 0, 0);
      add(32'h148, Z, CR, 1, 0, 1,      1, 32'h144, ADDR2, CR, 12, 1, 0);
      add(32'h148, Z, CR, 1, 0, 0,      0, Z32, Z32, C0, 0, 0, 0);
      add(32'h14C, W1, CR, 1, 0, 0,     1, 32'h148, Z, CR, 13, 0, 0);
      add(32'h150, W2, CR, 1, 1, 0,     1, 32'h14C, W1, CR, 14, 1, 0);
      add(32'h150, W2, CR, 1, 1, 0,     1, 32'h14C, W1, CR, 14, 1, 0);
      add(32'h150, W2, CR, 1, 1, 0,     1, 32'h14C, W1, CR, 14, 1, 0);
      add(32'h150, W2, CR, 1, 0, 0,     1, 32'h14C, W1, CR, 14, 0, 0);
      add(32'h154, W3, CR, 1, 0, 0,     1, 32'h150, W2, CR, 15, 0, 0);
      add(32'h158, INV, CR, 0, 0, 0,    1, 32'h154, W3, CR, 16, 0, 0);
      add(Z32, Z32, C0, 0, 0, 0,        0, 32'h158, INV, C0, 2, 0, 0);
      add(32'h15C, LW5, CL, 1, 0, 0,    0, Z32, Z32, C0, 0, 0, 0);
      add(32'h160, ADD8, CR, 1, 0, 0,   1, 32'h15C, LW5, CL, 5, 0, 0);
      add(32'h164, Q, CR, 1, 1, 1,      1, 32'h160, ADD8, CR, 8, 1, 0);
      add(32'h164, Q, CR, 1, 0, 0,      0, Z32, Z32, C0, 0, 0, 0);
      add(Z32, Z32, C0, 0, 0, 0,        1, 32'h164, Q, CR, 18, 0, 0);

      // Reset with an all-ones bundle presented as valid.
      reset = 1'b1;
      bus.if_bundle = '1;
      bus.if_valid  = 1'b1;
      bus.stall_in  = 1'b0;
      bus.flush_in  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid",  -1, 32'(bus.id_valid), 32'd0);
      chk("rst_ctrl",   -1, 32'(bus.id_ctrl), 32'd0);
      chk("rst_instr",  -1, bus.id_instr, 32'd0);
      chk("rst_pc",     -1, bus.id_nextPC, 32'd0);
      chk("rst_stall",  -1, 32'(bus.stall_if), 32'd0);
      chk("rst_bubble", -1, 32'(bus.ex_bubble), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].pc, vecs[i].ins, vecs[i].ctl, vecs[i].v, vecs[i].st, vecs[i].fl);
         #1;
         chk("id_valid",  i, 32'(bus.id_valid), 32'(vecs[i].e_v));
         chk("id_nextPC", i, bus.id_nextPC, vecs[i].e_pc);
         chk("id_instr",  i, bus.id_instr, vecs[i].e_ins);
         chk("id_ctrl",   i, 32'(bus.id_ctrl), 32'(vecs[i].e_ctl));
         chk("id_rs1",    i, 32'(bus.id_rs1), 32'(vecs[i].e_ins[6:10]));
         chk("id_rs2",    i, 32'(bus.id_rs2), 32'(vecs[i].e_ins[11:15]));
         chk("id_rd",     i, 32'(bus.id_rd), 32'(vecs[i].e_rd));
         chk("stall_if",  i, 32'(bus.stall_if), 32'(vecs[i].e_sif));
         chk("ex_bubble", i, 32'(bus.ex_bubble), 32'(vecs[i].e_bub));
         @(negedge clk);
      end

      // Reset dominates an active load-use hazard and a flush.
      drive(32'h200, LW5, CL, 1, 0, 0);
      @(negedge clk);
      drive(32'h204, ADD6, CR, 1, 0, 0);
      @(negedge clk);
      drive(32'h208, NX, CR, 1, 0, 0);
      #1;
      chk("pre_rst_hazard", 100, 32'(bus.ex_bubble), 32'd1);
      reset = 1'b1;
      bus.flush_in = 1'b1;
      @(negedge clk);
      bus.flush_in = 1'b0;
      #1;
      chk("mid_rst_valid", 101, 32'(bus.id_valid), 32'd0);
      chk("mid_rst_instr", 101, bus.id_instr, 32'd0);
      chk("mid_rst_ctrl",  101, 32'(bus.id_ctrl), 32'd0);
      chk("mid_rst_stall", 101, 32'(bus.stall_if), 32'd0);
      reset = 1'b0;
      drive(32'h204, ADD6, CR, 1, 0, 0);
      @(negedge clk);
      #1;
      chk("post_rst_instr", 102, bus.id_instr, ADD6);
      chk("post_rst_rd",    102, 32'(bus.id_rd), 32'd6);
      chk("post_rst_stall", 102, 32'(bus.stall_if), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
